// File: rtl/seg7_scan_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, the
// all-segments-off pattern and the default digit hold time.
package seg7_scan_pkg;

    // Default number of clk cycles each digit stays lit.
    localparam int PRESCALE_DEFAULT = 50000;

    // Segment/anode pattern with everything dark (active-low).
    localparam logic [7:0] ALL_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_hex2seg.sv
// Combinational nibble-to-glyph decoder, active-low {g..a}.
module hex2seg
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; every nibble value has a defined glyph.
    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner. A free-running prescaler
// steps the digit index; a pending/shadow register pair guarantees that a
// whole frame (digits 0..7) is always drawn from one captured word.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic [7:0]  point_i,
    input  logic [7:0]  blank_i,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o,
    output logic [2:0]  digit_o,
    output logic        frame_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          term_cnt;
    logic          wrap;

    logic [31:0]   pend_data_q, pend_data_d;
    logic [7:0]    pend_point_q, pend_point_d;
    logic [7:0]    pend_blank_q, pend_blank_d;
    logic [31:0]   shad_data_q, shad_data_d;
    logic [7:0]    shad_point_q, shad_point_d;
    logic [7:0]    shad_blank_q, shad_blank_d;

    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    digit_q, digit_d;
    logic          frame_q, frame_d;

    logic [3:0]    cur_nib;
    logic [6:0]    cur_glyph;
    logic [7:0]    zero_from;
    logic          zero_acc;
    logic          cur_blank;

    // Scan timing: prescaler wraps at PRESCALE-1 and steps the digit index.
    always_comb begin
        term_cnt = (cnt_q == CW'(PRESCALE - 1));
        cnt_d    = term_cnt ? '0 : cnt_q + CW'(1);
        idx_d    = term_cnt ? idx_q + 3'd1 : idx_q;
        wrap     = term_cnt && (idx_q == 3'd7);
    end

    // Pending takes every load; shadow only changes at a 7->0 wrap, and a
    // load landing on the wrap bypasses pending so it is shown immediately.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_point_d = pend_point_q;
        pend_blank_d = pend_blank_q;
        shad_data_d  = shad_data_q;
        shad_point_d = shad_point_q;
        shad_blank_d = shad_blank_q;
        if (load_i) begin
            pend_data_d  = data_i;
            pend_point_d = point_i;
            pend_blank_d = blank_i;
        end
        if (wrap) begin
            shad_data_d  = load_i ? data_i  : pend_data_q;
            shad_point_d = load_i ? point_i : pend_point_q;
            shad_blank_d = load_i ? blank_i : pend_blank_q;
        end
    end

    // zero_from[k] is set when shadow nibbles k..7 are all zero.
    always_comb begin
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int k = 7; k >= 0; k--) begin
            zero_acc     = zero_acc & (shad_data_q[4*k +: 4] == 4'h0);
            zero_from[k] = zero_acc;
        end
    end

    assign cur_nib = shad_data_q[{idx_q, 2'b00} +: 4];

    hex2seg u_hex2seg (
        .nib_i (cur_nib),
        .seg_o (cur_glyph)
    );

    // Next output pattern for the digit currently selected by the index.
    always_comb begin
        cur_blank = shad_blank_q[idx_q]
                  | (BLANK_LZ && (idx_q != 3'd0) && zero_from[idx_q]);
        an_d      = ~(8'd1 << idx_q);
        seg_d     = cur_blank ? ALL_OFF : {~shad_point_q[idx_q], cur_glyph};
        digit_d   = idx_q;
        frame_d   = wrap;
    end

    // State and output registers; reset darkens the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_point_q <= '0;
            pend_blank_q <= '0;
            shad_data_q  <= '0;
            shad_point_q <= '0;
            shad_blank_q <= '0;
            an_q         <= ALL_OFF;
            seg_q        <= ALL_OFF;
            digit_q      <= '0;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_point_q <= pend_point_d;
            pend_blank_q <= pend_blank_d;
            shad_data_q  <= shad_data_d;
            shad_point_q <= shad_point_d;
            shad_blank_q <= shad_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign digit_o = digit_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (PRESCALE=4 with leading-zero blanking,
// PRESCALE=1 without) driven from shared inputs, an arithmetic reference
// model compared every cycle, and literal checks on the key scenarios.
module tb_seg7_scan;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        load_i;
    logic [7:0]  point_i;
    logic [7:0]  blank_i;

    logic [7:0]  an_w    [2];
    logic [7:0]  seg_w   [2];
    logic [2:0]  digit_w [2];
    logic        frame_w [2];

    always #5 clk = ~clk;

    seg7_scan #(.PRESCALE(4), .BLANK_LZ(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .data_i(data_i), .load_i(load_i),
        .point_i(point_i), .blank_i(blank_i),
        .an_o(an_w[0]), .seg_o(seg_w[0]), .digit_o(digit_w[0]), .frame_o(frame_w[0])
    );

    seg7_scan #(.PRESCALE(1), .BLANK_LZ(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .data_i(data_i), .load_i(load_i),
        .point_i(point_i), .blank_i(blank_i),
        .an_o(an_w[1]), .seg_o(seg_w[1]), .digit_o(digit_w[1]), .frame_o(frame_w[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int P_OF  [2] = '{4, 1};
    localparam bit LZ_OF [2] = '{1'b1, 1'b0};

    int          m_e  [2];
    logic [31:0] m_pd [2];
    logic [7:0]  m_pp [2];
    logic [7:0]  m_pb [2];
    logic [31:0] m_sd [2];
    logic [7:0]  m_sp [2];
    logic [7:0]  m_sb [2];
    logic [7:0]  ex_an  [2];
    logic [7:0]  ex_seg [2];
    logic [2:0]  ex_dig [2];
    logic        ex_frm [2];

    function automatic int m_index(input int e, input int p);
        return (e / p) % 8;
    endfunction

    function automatic bit m_wrap(input int e, input int p);
        return ((e % p) == p - 1) && (m_index(e, p) == 7);
    endfunction

    function automatic logic [6:0] m_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] m_seg(input logic [31:0] d, input logic [7:0] pt,
                                         input logic [7:0] bl, input int k, input bit lz);
        logic [31:0] upper;
        logic [3:0]  nib;
        upper = d >> (4 * k);
        nib   = upper[3:0];
        if (bl[k] || (lz && k != 0 && upper == 32'd0)) return 8'hFF;
        return {~pt[k], m_glyph(nib)};
    endfunction

    // Time-indexed model: digit index comes from edges since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_e[i]  <= 0;
                m_pd[i] <= '0;  m_pp[i] <= '0;  m_pb[i] <= '0;
                m_sd[i] <= '0;  m_sp[i] <= '0;  m_sb[i] <= '0;
                ex_an[i]  <= 8'hFF;
                ex_seg[i] <= 8'hFF;
                ex_dig[i] <= 3'd0;
                ex_frm[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ex_dig[i] <= 3'(m_index(m_e[i], P_OF[i]));
                ex_an[i]  <= ~(8'h01 << m_index(m_e[i], P_OF[i]));
                ex_seg[i] <= m_seg(m_sd[i], m_sp[i], m_sb[i], m_index(m_e[i], P_OF[i]), LZ_OF[i]);
                ex_frm[i] <= m_wrap(m_e[i], P_OF[i]);
                m_e[i]    <= m_e[i] + 1;
                if (load_i) begin
                    m_pd[i] <= data_i;  m_pp[i] <= point_i;  m_pb[i] <= blank_i;
                end
                if (m_wrap(m_e[i], P_OF[i])) begin
                    m_sd[i] <= load_i ? data_i  : m_pd[i];
                    m_sp[i] <= load_i ? point_i : m_pp[i];
                    m_sb[i] <= load_i ? blank_i : m_pb[i];
                end
            end
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_an%0d", i),    an_w[i],              ex_an[i]);
            chk($sformatf("model_seg%0d", i),   seg_w[i],             ex_seg[i]);
            chk($sformatf("model_digit%0d", i), {5'd0, digit_w[i]},   {5'd0, ex_dig[i]});
            chk($sformatf("model_frame%0d", i), {7'd0, frame_w[i]},   {7'd0, ex_frm[i]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
        @(negedge clk);
        data_i  = d;
        point_i = p;
        blank_i = b;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_w[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", {7'd0, frame_w[0]}, 8'h01);
    endtask

    task automatic wait_digit0(input logic [2:0] k);
        int n;
        n = 0;
        while (digit_w[0] != k && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("digit_seen", {5'd0, digit_w[0]}, {5'd0, k});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] vec_d [4];
    logic [7:0]  vec_p [4];
    logic [7:0]  vec_b [4];
    logic [7:0]  lit;

    initial begin
        vec_d = '{32'h0000_00F0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h00A0_0000};
        vec_p = '{8'h00, 8'hA5, 8'hFF, 8'h00};
        vec_b = '{8'h00, 8'h18, 8'h00, 8'h01};

        rst = 1'b1;  data_i = '0;  load_i = 1'b0;  point_i = '0;  blank_i = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_an",    an_w[i],              8'hFF);
            chk("rst_seg",   seg_w[i],             8'hFF);
            chk("rst_digit", {5'd0, digit_w[i]},   8'h00);
            chk("rst_frame", {7'd0, frame_w[i]},   8'h00);
        end
        rst = 1'b0;

        // First edges after release; PRESCALE=1 rotates every cycle.
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            chk("p1_rotate_an", an_w[1], ~(8'h01 << (j % 8)));
            chk("p1_seg_zero",  seg_w[1], 8'hC0);
            chk("p1_frame",     {7'd0, frame_w[1]}, (j == 7) ? 8'h01 : 8'h00);
            if (j == 0) begin
                chk("first_an",  an_w[0],  8'hFE);
                chk("first_seg", seg_w[0], 8'hC0);
            end
        end

        // Old word applied, then a new one loaded mid-frame at index 3.
        pulse_load(32'h0000_0005, 8'h00, 8'h00);
        wait_frame();
        wait_digit0(3'd3);
        pulse_load(32'h1234_ABCD, 8'h00, 8'h00);
        wait_frame();
        chk("old_digit7_held",  seg_w[0], 8'hFF);
        @(negedge clk);
        chk("new_digit0",       seg_w[0], 8'hA1);
        chk("new_digit0_an",    an_w[0],  8'hFE);
        wait_frame();
        chk("new_digit7",       seg_w[0], 8'hF9);
        chk("new_digit7_an",    an_w[0],  8'h7F);

        // Load landing exactly on the 7->0 wrap edge.
        repeat (31) @(posedge clk);
        @(negedge clk);
        data_i = 32'h8888_8888;  point_i = 8'h01;  blank_i = 8'h00;  load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        chk("wrap_frame",          {7'd0, frame_w[0]}, 8'h01);
        chk("wrap_prev_digit7",    seg_w[0], 8'hF9);
        @(negedge clk);
        chk("load_on_wrap_digit0", seg_w[0], 8'h00);

        // Leading-zero blanking, then forced blank of digit 2.
        pulse_load(32'h0000_0800, 8'h00, 8'h00);
        wait_frame();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            lit = (k < 2) ? 8'hC0 : (k == 2) ? 8'h80 : 8'hFF;
            chk("lz_digit", seg_w[0], lit);
            repeat (4) @(negedge clk);
        end
        pulse_load(32'h0000_0800, 8'h00, 8'h04);
        wait_frame();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            lit = (k < 2) ? 8'hC0 : 8'hFF;
            chk("blank_digit", seg_w[0], lit);
            repeat (4) @(negedge clk);
        end

        // Mid-scan reset with a pending load outstanding.
        repeat (10) @(negedge clk);
        pulse_load(32'h1111_1111, 8'hFF, 8'h00);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_an",    an_w[i],            8'hFF);
            chk("midrst_seg",   seg_w[i],           8'hFF);
            chk("midrst_digit", {5'd0, digit_w[i]}, 8'h00);
            chk("midrst_frame", {7'd0, frame_w[i]}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("after_rst_an",  an_w[i],  8'hFE);
            chk("after_rst_seg", seg_w[i], 8'hC0);
        end
        repeat (80) @(negedge clk);

        // Assorted words, points and blanks checked by the model.
        for (int v = 0; v < 4; v++) begin
            pulse_load(vec_d[v], vec_p[v], vec_b[v]);
            repeat (70) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, clk cycles each digit is held (legal range 1..2^20).
REQ-002 Parameter BLANK_LZ, default 0, 1 enables leading-zero blanking.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_i  input  32  word to display, eight hex nibbles; nibble k (data_i[4k+3:4k]) drives digit k, digit 0 rightmost.
REQ-006 load_i  input  1  capture strobe for data_i, point_i, blank_i.
REQ-007 point_i  input  8  per-digit decimal point enable, bit k = digit k.
REQ-008 blank_i  input  8  per-digit forced blank, bit k = digit k.
REQ-009 an_o  output  8  digit enables, active-low, one-hot-zero; bit k = digit k.
REQ-010 seg_o  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-011 digit_o  output  3  index of the digit currently shown on an_o/seg_o.
REQ-012 frame_o  output  1  one-cycle pulse at each 7->0 digit wrap.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and wraps to 0; the terminal count is the cycle in which the count equals PRESCALE-1.
REQ-014 On terminal count, the digit index increments modulo 8 (7 wraps to 0); with PRESCALE=1 it advances every cycle.
REQ-015 frame_o SHALL be 1 exactly in the cycle following a 7->0 index wrap, otherwise 0.
REQ-016 load_i high captures data_i/point_i/blank_i into a pending register; a later load overwrites an earlier unapplied one.
REQ-017 Pending contents transfer to the shadow (displayed) register only on a 7->0 wrap, so a frame never shows mixed words.
REQ-018 load_i coinciding with a 7->0 wrap writes data_i/point_i/blank_i into both pending and shadow in that cycle.
REQ-019 an_o, seg_o and digit_o are registered; they reflect index and shadow contents with one cycle latency.
REQ-020 For digit k: an_o = ~(1<<k); seg_o[6:0] = hex decode of shadow nibble k; seg_o[7] = ~point bit k.
REQ-021 Hex decode, active-low {g..a}: 0->40h, 1->79h, 8->00h, D->21h; all 16 glyphs 0-9, A, b, C, d, E, F are defined.
REQ-022 A blanked digit drives seg_o = FFh while an_o keeps its normal one-hot-zero pattern.
REQ-023 Digit k is blanked if shadow blank bit k = 1, or if BLANK_LZ=1, k != 0, and shadow nibbles k..7 are all zero.
REQ-024 No input affects the prescaler or index; scan timing is free-running.

Reset
REQ-025 rst asynchronously clears prescaler, index, pending, and shadow to 0.
REQ-026 During rst: an_o = FFh, seg_o = FFh, digit_o = 0, frame_o = 0.
REQ-027 In the first clk edge after rst deasserts: an_o = FEh, seg_o = C0h (digit 0 shows 0 unless BLANK_LZ affects a nonzero k).
REQ-028 rst mid-frame discards pending and shadow data; there is no partial-frame recovery.

Structure
REQ-029 The shared package holds the 16-entry hex-to-segment constant table, the ALL_OFF=8'hFF constant, and the PRESCALE default.
REQ-030 A combinational sub-module hex2seg (4-bit nibble in, 7-bit active-low segments out) is instantiated once.
REQ-031 Index, prescaler, pending/shadow registers, and output registers live in seg7_scan.

Verification
REQ-032 PRESCALE=4: rst pulse mid-scan -> outputs FFh/FFh/0 immediately; one edge after release, an_o=FEh, seg_o=C0h.
REQ-033 PRESCALE=4, load 1234ABCDh at index 3 -> old word held until wrap; then digit0 seg_o=A1h, digit7 seg_o=F9h, frame_o one pulse.
REQ-034 load_i exactly on 7->0 wrap with 88888888h, point_i=01h -> digit0 seg_o=00h in the following cycle.
REQ-035 BLANK_LZ=1, load 00000800h -> digits 3..7 seg_o=FFh, digits 0,1 seg_o=C0h, digit2 seg_o=80h; blank_i=04h additionally blanks digit 2.
REQ-036 PRESCALE=1 -> an_o rotates FEh, FDh, ... 7Fh, FEh on consecutive cycles; frame_o every 8th cycle.
